// File: rtl/irrigation_controller.sv
// Soil-moisture irrigation controller: synchronizes the sensor inputs, sequences
// IDLE/WATER/PURGE/FAULT on tick-based timers, and drives registered pump/valve commands.
module irrigation_controller #(
  parameter int unsigned SPRAY_TIME = 10,
  parameter int unsigned DRIP_TIME  = 30,
  parameter int unsigned PURGE_TIME = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       h_low,
  input  logic       h_high,
  input  logic       tank_low,
  input  logic       mode_sel,
  output logic       valve_drip,
  output logic       valve_spray,
  output logic       pump_on,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WATER = 2'b01;
  localparam logic [1:0] PURGE = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  localparam logic [7:0] SPRAY_LIM = 8'(SPRAY_TIME);
  localparam logic [7:0] DRIP_LIM  = 8'(DRIP_TIME);
  localparam logic [7:0] PURGE_LIM = 8'(PURGE_TIME);

  // Bit order in both synchronizer stages: {tank_low, h_high, h_low}
  logic [2:0] r_sync_meta;
  logic [2:0] r_sync;
  logic       w_h_low_s;
  logic       w_h_high_s;
  logic       w_tank_low_s;
  logic       w_fault;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic [7:0] w_limit;
  logic       r_mode;
  logic       w_mode_nxt;

  logic       r_valve_drip;
  logic       r_valve_spray;
  logic       r_pump_on;
  logic       r_alarm;

  assign w_h_low_s    = r_sync[0];
  assign w_h_high_s   = r_sync[1];
  assign w_tank_low_s = r_sync[2];
  assign w_fault      = w_tank_low_s | (w_h_low_s & w_h_high_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= {tank_low, h_high, h_low};
      r_sync      <= r_sync_meta;
    end
  end

  always_comb begin
    w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    w_limit     = r_mode ? SPRAY_LIM : DRIP_LIM;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    if (w_fault) begin
      w_state_nxt = FAULT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_h_low_s && !w_h_high_s) begin
            w_state_nxt = WATER;
            w_cnt_nxt   = '0;
            w_mode_nxt  = mode_sel;
          end
        end
        WATER: begin
          // A coincident tick and saturation sensor leave WATER exactly once
          if (w_h_high_s || (tick && (w_cnt_inc == w_limit))) begin
            w_state_nxt = PURGE;
            w_cnt_nxt   = '0;
          end else if (tick) begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        PURGE: begin
          if (tick) begin
            if (w_cnt_inc == PURGE_LIM) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        FAULT: begin
          // Fault was sampled false at this edge, so it has held false for a full cycle
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Outputs follow the state one cycle after entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valve_drip  <= 1'b0;
      r_valve_spray <= 1'b0;
      r_pump_on     <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      r_valve_drip  <= ((r_state == WATER) || (r_state == PURGE)) && !r_mode;
      r_valve_spray <= ((r_state == WATER) || (r_state == PURGE)) && r_mode;
      r_pump_on     <= (r_state == WATER);
      r_alarm       <= (r_state == FAULT);
    end
  end

  assign valve_drip  = r_valve_drip;
  assign valve_spray = r_valve_spray;
  assign pump_on     = r_pump_on;
  assign alarm       = r_alarm;
  assign state       = r_state;

endmodule

// File: tb/tb_irrigation_controller.sv
// Self-checking bench for irrigation_controller: hand-derived vector table, corner
// sequences and randomized traffic compared against a behavioural model.
module tb_irrigation_controller;

  localparam int SPRAY_T = 10;
  localparam int DRIP_T  = 30;
  localparam int PURGE_T = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       h_low = 1'b0;
  logic       h_high = 1'b0;
  logic       tank_low = 1'b0;
  logic       mode_sel = 1'b0;
  logic       valve_drip;
  logic       valve_spray;
  logic       pump_on;
  logic       alarm;
  logic [1:0] state;

  int n_vec = 0;
  int n_mis = 0;

  irrigation_controller #(
    .SPRAY_TIME(SPRAY_T),
    .DRIP_TIME (DRIP_T),
    .PURGE_TIME(PURGE_T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .h_low      (h_low),
    .h_high     (h_high),
    .tank_low   (tank_low),
    .mode_sel   (mode_sel),
    .valve_drip (valve_drip),
    .valve_spray(valve_spray),
    .pump_on    (pump_on),
    .alarm      (alarm),
    .state      (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // States named by meaning: 0 idle, 1 watering, 2 purging, 3 fault
  int       m_st = 0;
  int       m_ticks = 0;
  bit       m_mode = 1'b0;
  bit [3:0] m_outs = 4'b0000;   // {alarm, pump_on, valve_spray, valve_drip}
  bit       q_hl[$] = '{1'b0, 1'b0};
  bit       q_hh[$] = '{1'b0, 1'b0};
  bit       q_tl[$] = '{1'b0, 1'b0};

  function automatic bit [3:0] outs_of(int st, bit md);
    case (st)
      1:       return {1'b0, 1'b1, md, ~md};
      2:       return {1'b0, 1'b0, md, ~md};
      3:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step();
    bit hl, hh, tl;
    int lim;
    if (reset) begin
      q_hl = '{1'b0, 1'b0};
      q_hh = '{1'b0, 1'b0};
      q_tl = '{1'b0, 1'b0};
      m_st = 0; m_ticks = 0; m_mode = 1'b0; m_outs = 4'b0000;
      return;
    end
    m_outs = outs_of(m_st, m_mode);
    hl = q_hl.pop_back(); q_hl.push_front(h_low);
    hh = q_hh.pop_back(); q_hh.push_front(h_high);
    tl = q_tl.pop_back(); q_tl.push_front(tank_low);
    lim = m_mode ? SPRAY_T : DRIP_T;
    if (tl || (hl && hh)) m_st = 3;
    else if (m_st == 0) begin
      if (hl && !hh) begin m_st = 1; m_ticks = 0; m_mode = mode_sel; end
    end else if (m_st == 1) begin
      if (hh) begin m_st = 2; m_ticks = 0; end
      else if (tick) begin
        m_ticks++;
        if (m_ticks >= lim) begin m_st = 2; m_ticks = 0; end
      end
    end else if (m_st == 2) begin
      if (tick) begin
        m_ticks++;
        if (m_ticks >= PURGE_T) m_st = 0;
      end
    end else m_st = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] est, input logic [3:0] eo);
    logic [3:0] ao;
    ao = {alarm, pump_on, valve_spray, valve_drip};
    n_vec++;
    if (state !== est || ao !== eo) begin
      n_mis++;
      $display("FAIL %s: got state=%b outs=%b, expected state=%b outs=%b", name, state, ao, est, eo);
    end
  endtask

  task automatic run_model(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(name, 2'(m_st), m_outs);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; h_low = 1'b0; h_high = 1'b0; tank_low = 1'b0; mode_sel = 1'b0;
    run_model("reset", 1);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [1:0] target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (state === target) ok = 1'b1;
      else run_model(name, 1);
    end
    if (!ok && state !== target) begin
      n_vec++; n_mis++;
      $display("FAIL %s_timeout: got state=%b, expected state=%b within %0d cycles", name, state, target, budget);
    end
  endtask

  // Interlock holds every cycle regardless of stimulus
  always @(negedge clk) begin
    n_vec++;
    if ((pump_on && !valve_drip && !valve_spray) || (valve_drip && valve_spray)) begin
      n_mis++;
      $display("FAIL interlock: got pump=%b drip=%b spray=%b, expected pump only with exactly one valve",
               pump_on, valve_drip, valve_spray);
    end
  end

  // ---------------- hand-derived vector table ----------------
  typedef struct {
    logic       rst, tk, hl, hh, tl, ms;
    logic [1:0] st;
    logic [3:0] outs;
  } vec_t;

  vec_t vecs[18];

  initial begin
    //           rst  tk   hl   hh   tl   ms   state  {alm,pmp,spr,drp}
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 4'b0000};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b00, 4'b0000};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b00, 4'b0000};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b01, 4'b0000};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 2'b01, 4'b0110};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b01, 4'b0110};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b01, 4'b0110};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b10, 4'b0110};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10, 4'b0010};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10, 4'b0010};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00, 4'b0010};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 4'b0000};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 4'b0000};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b11, 4'b0000};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b11, 4'b1000};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b11, 4'b1000};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 4'b1000};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 4'b0000};

    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst; tick = vecs[i].tk; h_low = vecs[i].hl;
      h_high = vecs[i].hh; tank_low = vecs[i].tl; mode_sel = vecs[i].ms;
      step();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
    end

    // Sprinkler run on a slow tick: 10 ticks watering, 3 ticks purge
    do_reset();
    h_low = 1'b1; mode_sel = 1'b1;
    for (int c = 0; c < 90; c++) begin
      tick = (c % 4 == 0);
      run_model("spray_run", 1);
    end

    // Drip timeout with tick every cycle, then reset mid-watering at tick 7
    do_reset();
    h_low = 1'b1; mode_sel = 1'b0; tick = 1'b1;
    run_model("drip_timeout", 45);
    do_reset();
    h_low = 1'b1; tick = 1'b1;
    wait_state("water_entry", 2'b01, 10);
    run_model("water_ticks", 7);
    reset = 1'b1;
    step();
    check("reset_midwater", 2'b00, 4'b0000);
    reset = 1'b0;
    run_model("after_reset", 20);

    // mode_sel toggling must not disturb the latched valve choice
    do_reset();
    h_low = 1'b1; mode_sel = 1'b1;
    for (int c = 0; c < 60; c++) begin
      mode_sel = ~mode_sel;
      tick = c[0];
      run_model("mode_toggle", 1);
    end

    // Dry and saturated together is a sensor fault; clearing h_high recovers
    do_reset();
    h_low = 1'b1; h_high = 1'b1;
    run_model("hl_hh", 4);
    check("hl_hh_fault", 2'b11, 4'b1000);
    h_high = 1'b0;
    run_model("hl_hh_recover", 8);

    // Saturation arriving around the drip limit tick
    for (int off = 25; off < 33; off++) begin
      do_reset();
      h_low = 1'b1; mode_sel = 1'b0; tick = 1'b1;
      wait_state("sweep_entry", 2'b01, 10);
      run_model("sweep_water", off);
      h_high = 1'b1; h_low = 1'b0;
      run_model("sweep_exit", 12);
    end

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      tick     = ($urandom_range(0, 1) == 1);
      mode_sel = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) h_low = ~h_low;
      if ($urandom_range(0, 39) == 0) h_high = ~h_high;
      if (tank_low ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 79) == 0)) tank_low = ~tank_low;
      run_model("random", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/irrigation_controller.md
IRRIGATION_CONTROLLER -- requirements
Module: irrigation_controller

Interface
REQ-001 Parameter SPRAY_TIME, default 10, SHALL set the maximum watering duration in ticks for sprinkler mode.
REQ-002 Parameter DRIP_TIME, default 30, SHALL set the maximum watering duration in ticks for drip mode.
REQ-003 Parameter PURGE_TIME, default 3, SHALL set the post-watering purge duration in ticks.
REQ-004 Parameter range: every time parameter SHALL be 1..255.
REQ-005 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 tick  input  1  SHALL be a one-clk-wide timebase enable, 1 Hz nominal; only tick-qualified cycles advance timers.
REQ-008 h_low  input  1  SHALL indicate soil dry (asynchronous, from sensor).
REQ-009 h_high  input  1  SHALL indicate soil saturated (asynchronous, from sensor).
REQ-010 tank_low  input  1  SHALL indicate reservoir below minimum (asynchronous, from sensor).
REQ-011 mode_sel  input  1  SHALL select the watering mode: 0 = drip, 1 = sprinkler.
REQ-012 valve_drip  output  1  SHALL be the drip valve open command.
REQ-013 valve_spray  output  1  SHALL be the sprinkler valve open command.
REQ-014 pump_on  output  1  SHALL be the pump run command.
REQ-015 alarm  output  1  SHALL indicate the fault state.
REQ-016 state  output  2  SHALL expose the FSM state encoding.

Function
REQ-017 Input sync: h_low, h_high and tank_low SHALL each pass through a two-flop synchronizer; the FSM SHALL use only the synchronized versions (h_low_s, h_high_s, tank_low_s), so an input change reaches the FSM 2 clk later.
REQ-018 States and encoding SHALL be IDLE=00, WATER=01, PURGE=10, FAULT=11.
REQ-019 Fault condition SHALL be tank_low_s=1 or (h_low_s=1 and h_high_s=1).
REQ-020 Fault priority: in any state, the fault condition SHALL force the next state to FAULT, overriding every other transition.
REQ-021 IDLE to WATER: h_low_s=1 and h_high_s=0 SHALL cause a transition to WATER; mode_sel SHALL be latched into mode_r on that edge and held until the next WATER entry.
REQ-022 WATER timer: the tick counter SHALL clear on entry and increment on each tick.
REQ-023 WATER exit: the FSM SHALL go to PURGE when h_high_s=1, or on the tick that brings the count to the mode limit (DRIP_TIME or SPRAY_TIME per mode_r).
REQ-024 PURGE: the counter SHALL clear on entry; on the tick bringing the count to PURGE_TIME, the FSM SHALL go to IDLE.
REQ-025 FAULT exit: the FSM SHALL return to IDLE only when the fault condition has been false for one full clk cycle; no timer applies.
REQ-026 Outputs SHALL be registered and take effect in the cycle after the state is entered.
REQ-027 WATER outputs: pump_on=1, with valve_drip=~mode_r and valve_spray=mode_r.
REQ-028 PURGE outputs: pump_on=0; the valve selected by mode_r SHALL stay open to drain.
REQ-029 IDLE outputs: all valves and pump_on SHALL be 0.
REQ-030 FAULT outputs: alarm=1; all valves and pump_on SHALL be 0.
REQ-031 Pump/valve interlock: pump_on=1 SHALL never coincide with both valves closed, and valve_drip and valve_spray SHALL never both be 1.
REQ-032 Counter: 8 bits, saturating at 255, with no wrap-around.
REQ-033 Simultaneous tick and h_high_s in WATER SHALL go to PURGE, counted once only.
REQ-034 A tick with h_high_s asserted in the same cycle as the count reaching the limit SHALL go to PURGE only once.
REQ-035 A mode_sel change during WATER or PURGE SHALL be ignored.

Reset
REQ-036 reset=1 at a clk edge SHALL set state=IDLE, all outputs to 0, counter=0, mode_r=0 and the synchronizer flops to 0, overriding every transition including a mid-WATER or mid-FAULT reset.
REQ-037 After reset release, the first state change SHALL occur no earlier than 2 clk later, due to the synchronizer delay.

Verification
REQ-038 Scenario: h_low=1, mode_sel=1, 12 ticks -> WATER with valve_spray=1 and pump_on=1; after tick 10, PURGE for 3 ticks with pump_on=0; then IDLE.
REQ-039 Scenario: drip mode, h_high rises at tick 5 -> PURGE 3 clk after the h_high edge, with valve_drip=1 and pump_on=0; IDLE after 3 ticks.
REQ-040 Scenario: tank_low pulses mid-WATER -> FAULT with alarm=1 and all outputs 0; return to IDLE 2+1 clk after tank_low falls; re-enter WATER only if h_low is still 1.
REQ-041 Scenario: h_low=1 and h_high=1 together in IDLE -> FAULT; clearing h_high -> IDLE, then WATER.
REQ-042 Scenario: reset asserted at tick 7 of WATER -> next clk state=00 and all outputs 0; counter restarts from 0 on the next WATER entry.
REQ-043 Scenario: mode_sel toggled each clk during WATER -> valve selection constant throughout; interlock (REQ-031) checked every cycle by assertion.
